// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types and register indices for the pipeline sequencing controller.
// Register i sits between stage i and stage i+1.
package pipeline_ctrl_unit_pkg;

   localparam int PIPE_CNT_W = 16;
   typedef logic [PIPE_CNT_W-1:0] pipe_cnt_t;

   localparam int REG_IFID = 0;
   localparam int REG_IDEX = 1;
   localparam int REG_EXM  = 2;
   localparam int REG_MWB  = 3;

   // What the pipeline does in a given cycle, in priority-resolved form.
   typedef enum logic [1:0] {
      ACT_STALL   = 2'd0,
      ACT_ADVANCE = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } pipe_act_e;

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Event counter that sticks at all-ones; one cycle from en to the new count.
// Cleared only by the asynchronous reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencing: register enables/flushes, PC enable, dmem handshake, sticky halt.
// Enables and requests are combinational from inputs and state; a pending dmem access stalls everything.
module pipeline_ctrl_unit
   import pipeline_ctrl_unit_pkg::*;
#(
   parameter int NSTAGES    = 5,
   parameter int BUBBLE_REG = REG_IDEX,
   parameter int MEM_REG    = REG_EXM,
   parameter int FLUSH_REGS = 2,
   parameter int CNT_W      = PIPE_CNT_W,
   localparam int NREGS     = NSTAGES - 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic             load_use,
   input  logic             redirect,
   input  logic             halt_in,
   output logic             pc_en,
   output logic [NREGS-1:0] reg_en,
   output logic [NREGS-1:0] reg_flush,
   output logic [NREGS-1:0] reg_valid,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             mem_capture,
   output logic             halt,
   output logic [CNT_W-1:0] cnt_memstall,
   output logic [CNT_W-1:0] cnt_bubble,
   output logic [CNT_W-1:0] cnt_flush
);

   if (!((BUBBLE_REG < MEM_REG) && (MEM_REG < NREGS))) begin : g_bad_reg_order
      $error("pipeline_ctrl_unit: need BUBBLE_REG < MEM_REG < NREGS");
   end
   if (FLUSH_REGS > MEM_REG) begin : g_bad_flush_regs
      $error("pipeline_ctrl_unit: FLUSH_REGS must not exceed MEM_REG");
   end

   localparam logic [NREGS-1:0] FLUSH_MASK  = NREGS'((1 << FLUSH_REGS) - 1);
   localparam logic [NREGS-1:0] HOLD_MASK   = NREGS'((1 << BUBBLE_REG) - 1);
   localparam logic [NREGS-1:0] BUBBLE_MASK = NREGS'(1 << BUBBLE_REG);

   logic [NREGS-1:0] valid_q, valid_d;
   logic             mem_done_q, mem_done_d;
   logic             halt_q, halt_d;
   logic             pending;
   logic             advance;
   pipe_act_e        act;

   always_comb begin
      pending = valid_q[MEM_REG] & (mem_ren | mem_wen) & ~mem_done_q & ~halt_q;
      advance = ihit & ~halt_q & (~pending | dhit);
      if (!advance) begin
         act = ACT_STALL;
      end else if (redirect) begin
         act = ACT_FLUSH;
      end else if (load_use) begin
         act = ACT_BUBBLE;
      end else begin
         act = ACT_ADVANCE;
      end
   end

   always_comb begin
      pc_en     = 1'b0;
      reg_en    = '0;
      reg_flush = '0;
      case (act)
         ACT_ADVANCE: begin
            pc_en  = 1'b1;
            reg_en = '1;
         end
         ACT_FLUSH: begin
            pc_en     = 1'b1;
            reg_en    = '1;
            reg_flush = FLUSH_MASK;
         end
         // Front registers hold the stalled instruction; the bubble register loads a clear.
         ACT_BUBBLE: begin
            reg_en    = ~HOLD_MASK;
            reg_flush = BUBBLE_MASK;
         end
         default: ;
      endcase
   end

   always_comb begin
      valid_d    = ({valid_q[NREGS-2:0], 1'b1} & reg_en & ~reg_flush) | (valid_q & ~reg_en);
      // mem_done covers the gap between a completed dhit and the ihit that lets us advance.
      mem_done_d = advance ? 1'b0 : (mem_done_q | (dhit & pending & ~ihit));
      halt_d     = halt_q | (halt_in & valid_q[MEM_REG] & advance);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q    <= '0;
         mem_done_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         mem_done_q <= mem_done_d;
         halt_q     <= halt_d;
      end
   end

   assign reg_valid   = valid_q;
   assign dmemREN     = pending & mem_ren;
   assign dmemWEN     = pending & mem_wen;
   assign mem_capture = dhit & pending;
   assign halt        = halt_q;

   sat_counter #(.W(CNT_W)) u_cnt_memstall (
      .CLK  (CLK),
      .nRST (nRST),
      .en   (pending & ~dhit),
      .cnt  (cnt_memstall)
   );

   sat_counter #(.W(CNT_W)) u_cnt_bubble (
      .CLK  (CLK),
      .nRST (nRST),
      .en   (act == ACT_BUBBLE),
      .cnt  (cnt_bubble)
   );

   sat_counter #(.W(CNT_W)) u_cnt_flush (
      .CLK  (CLK),
      .nRST (nRST),
      .en   (act == ACT_FLUSH),
      .cnt  (cnt_flush)
   );

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed plus randomized bench for pipeline_ctrl_unit against a cycle-level reference model.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_pipeline_ctrl_unit;

   localparam int NREGS = 4;
   localparam int BUB   = 1;
   localparam int MEMR  = 2;
   localparam int FLR   = 2;

   logic CLK = 1'b0;
   logic nRST;
   logic ihit, dhit, mem_ren, mem_wen, load_use, redirect, halt_in;

   logic             pc_en, dmemREN, dmemWEN, mem_capture, halt;
   logic [NREGS-1:0] reg_en, reg_flush, reg_valid;
   logic [15:0]      cnt_memstall, cnt_bubble, cnt_flush;

   logic             d2_pc_en, d2_dmemREN, d2_dmemWEN, d2_mem_capture, d2_halt;
   logic [NREGS-1:0] d2_reg_en, d2_reg_flush, d2_reg_valid;
   logic [1:0]       d2_cnt_memstall, d2_cnt_bubble, d2_cnt_flush;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [NREGS-1:0] mv;
   bit               md, mh;
   int               c_stall, c_bub, c_fl;

   // observed values captured mid-cycle by step()
   logic             o_pc, o_ren, o_wen, o_cap;
   logic [NREGS-1:0] o_en, o_fl;

   always #5 CLK = ~CLK;

   pipeline_ctrl_unit dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .load_use(load_use), .redirect(redirect), .halt_in(halt_in),
      .pc_en(pc_en), .reg_en(reg_en), .reg_flush(reg_flush), .reg_valid(reg_valid),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .mem_capture(mem_capture), .halt(halt),
      .cnt_memstall(cnt_memstall), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
   );

   pipeline_ctrl_unit #(.CNT_W(2)) dut2 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .load_use(load_use), .redirect(redirect), .halt_in(halt_in),
      .pc_en(d2_pc_en), .reg_en(d2_reg_en), .reg_flush(d2_reg_flush), .reg_valid(d2_reg_valid),
      .dmemREN(d2_dmemREN), .dmemWEN(d2_dmemWEN), .mem_capture(d2_mem_capture), .halt(d2_halt),
      .cnt_memstall(d2_cnt_memstall), .cnt_bubble(d2_cnt_bubble), .cnt_flush(d2_cnt_flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input int c);
      return (c > 65535) ? 16'hFFFF : 16'(c);
   endfunction

   function automatic logic [1:0] sat2(input int c);
      return (c > 3) ? 2'd3 : 2'(c);
   endfunction

   task automatic chk_counters();
      chk("cnt_memstall", 32'(cnt_memstall), 32'(sat16(c_stall)));
      chk("cnt_bubble",   32'(cnt_bubble),   32'(sat16(c_bub)));
      chk("cnt_flush",    32'(cnt_flush),    32'(sat16(c_fl)));
      chk("sat2_memstall", 32'(d2_cnt_memstall), 32'(sat2(c_stall)));
      chk("sat2_bubble",   32'(d2_cnt_bubble),   32'(sat2(c_bub)));
      chk("sat2_flush",    32'(d2_cnt_flush),    32'(sat2(c_fl)));
   endtask

   // One clock cycle: apply inputs at negedge, check against the model, advance the model at posedge.
   task automatic step(input bit i_ih, input bit i_dh, input bit i_rn, input bit i_wn,
                       input bit i_lu, input bit i_rd, input bit i_hi);
      bit               pend, adv, bub, fl;
      logic [NREGS-1:0] e_en, e_fl, nv;
      ihit = i_ih; dhit = i_dh; mem_ren = i_rn; mem_wen = i_wn;
      load_use = i_lu; redirect = i_rd; halt_in = i_hi;
      #1;
      pend = mv[MEMR] && (i_rn || i_wn) && !md && !mh;
      adv  = i_ih && !mh && (!pend || i_dh);
      fl   = adv && i_rd;
      bub  = adv && i_lu && !i_rd;
      e_en = '0;
      e_fl = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (adv && !(bub && i < BUB)) e_en[i] = 1'b1;
         if ((fl && i < FLR) || (bub && i == BUB)) e_fl[i] = 1'b1;
      end
      o_pc = pc_en; o_en = reg_en; o_fl = reg_flush;
      o_ren = dmemREN; o_wen = dmemWEN; o_cap = mem_capture;
      chk("pc_en",       32'(pc_en),       32'(adv && !bub));
      chk("reg_en",      32'(reg_en),      32'(e_en));
      chk("reg_flush",   32'(reg_flush),   32'(e_fl));
      chk("reg_valid",   32'(reg_valid),   32'(mv));
      chk("dmemREN",     32'(dmemREN),     32'(pend && i_rn));
      chk("dmemWEN",     32'(dmemWEN),     32'(pend && i_wn));
      chk("mem_capture", 32'(mem_capture), 32'(pend && i_dh));
      chk("halt",        32'(halt),        32'(mh));
      chk_counters();
      // each enabled register takes its upstream neighbour's token (or a new one at reg 0)
      nv = mv;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (e_en[i]) nv[i] = (i == 0) ? 1'b1 : mv[i-1];
         if (e_fl[i]) nv[i] = 1'b0;
      end
      @(posedge CLK);
      if (i_hi && mv[MEMR] && adv) mh = 1'b1;
      if (adv) md = 1'b0;
      else if (i_dh && pend && !i_ih) md = 1'b1;
      mv = nv;
      if (pend && !i_dh) c_stall++;
      if (bub) c_bub++;
      if (fl) c_fl++;
      @(negedge CLK);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #1;
      chk("rst_async_ren", 32'(dmemREN), 32'd0);
      chk("rst_async_wen", 32'(dmemWEN), 32'd0);
      ihit = 0; dhit = 0; mem_ren = 0; mem_wen = 0; load_use = 0; redirect = 0; halt_in = 0;
      mv = '0; md = 0; mh = 0; c_stall = 0; c_bub = 0; c_fl = 0;
      repeat (2) @(negedge CLK);
      chk("rst_pc_en",     32'(pc_en),       32'd0);
      chk("rst_reg_en",    32'(reg_en),      32'd0);
      chk("rst_reg_flush", 32'(reg_flush),   32'd0);
      chk("rst_reg_valid", 32'(reg_valid),   32'd0);
      chk("rst_capture",   32'(mem_capture), 32'd0);
      chk("rst_halt",      32'(halt),        32'd0);
      chk_counters();
      nRST = 1'b1;
   endtask

   task automatic rand_step(input bit allow_halt);
      int op;
      op = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, op == 1, op == 2,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           allow_halt && ($urandom_range(0, 3) == 0));
   endtask

   initial begin
      ihit = 0; dhit = 0; mem_ren = 0; mem_wen = 0; load_use = 0; redirect = 0; halt_in = 0;
      do_reset();

      // pipeline fill
      step(1, 0, 0, 0, 0, 0, 0); chk("fill1", 32'(reg_valid), 32'h1);
      step(1, 0, 0, 0, 0, 0, 0); chk("fill2", 32'(reg_valid), 32'h3);
      step(1, 0, 0, 0, 0, 0, 0); chk("fill3", 32'(reg_valid), 32'h7);
      step(1, 0, 0, 0, 0, 0, 0); chk("fill4", 32'(reg_valid), 32'hF);

      // load with dhit on the fourth cycle
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 1, 0, 0, 0, 0);
         chk("load_ren_wait", 32'(o_ren), 32'd1);
         chk("load_en_wait",  32'(o_en),  32'h0);
      end
      step(1, 1, 1, 0, 0, 0, 0);
      chk("load_ren_hit", 32'(o_ren), 32'd1);
      chk("load_en_hit",  32'(o_en),  32'hF);
      chk("load_stalls",  32'(cnt_memstall), 32'd3);

      // store completes while fetch is still waiting
      step(0, 1, 0, 1, 0, 0, 0);
      chk("st_wen_hit", 32'(o_wen), 32'd1);
      chk("st_capture", 32'(o_cap), 32'd1);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("st_no_rereq", 32'(o_wen), 32'd0);
      chk("st_hold",     32'(o_en),  32'h0);
      step(1, 0, 0, 1, 0, 0, 0);
      chk("st_advance", 32'(o_en), 32'hF);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("st_done_clr", 32'(o_wen), 32'd1);
      step(1, 1, 0, 1, 0, 0, 0);

      // load-use bubble
      step(1, 0, 0, 0, 1, 0, 0);
      chk("lu_pc_en", 32'(o_pc), 32'd0);
      chk("lu_en",    32'(o_en), 32'hE);
      chk("lu_flush", 32'(o_fl), 32'h2);
      chk("lu_valid1", 32'(reg_valid[1]), 32'd0);
      chk("lu_count", 32'(cnt_bubble), 32'd1);

      // redirect beats load-use
      step(1, 0, 0, 0, 1, 1, 0);
      chk("rd_flush", 32'(o_fl), 32'h3);
      chk("rd_pc_en", 32'(o_pc), 32'd1);
      chk("rd_count", 32'(cnt_flush), 32'd1);
      chk("rd_nobub", 32'(cnt_bubble), 32'd1);

      repeat (400) rand_step(1'b0);

      // reset while a read request is outstanding
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      ihit = 1; dhit = 0; mem_ren = 1; mem_wen = 0;
      #1;
      chk("pre_rst_ren", 32'(dmemREN), 32'd1);
      do_reset();

      repeat (300) rand_step(1'b0);

      // sticky halt
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1);
      chk("halt_set", 32'(halt), 32'd1);
      for (int k = 0; k < 20; k++) begin
         rand_step(1'b1);
         chk("halt_en",  32'(o_en),  32'h0);
         chk("halt_pc",  32'(o_pc),  32'd0);
         chk("halt_ren", 32'(o_ren), 32'd0);
      end
      chk("sat2_final", 32'(d2_cnt_memstall), 32'(sat2(c_stall)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
